job_tx: RTL and testbench

JOB_TX -- requirements
Module: job_tx

---
 rtl/aoc_uart_pkg.sv | 75 +++++++
 rtl/resp_collect.sv | 67 ++++++
 rtl/job_tx.sv | 170 +++++++++++++++++
 tb/tb_job_tx.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aoc_uart_pkg.sv
// Shared constants, state encoding and helpers for the AoC UART job path.
// Imported by job_tx and resp_collect.
package aoc_uart_pkg;

    localparam logic [7:0] HDR_MAGIC    = 8'hAA;
    localparam int         RESULT_BYTES = 8;
    localparam int         HDR_BYTES    = 4;

    localparam int LINE_BYTES_MIN = 1;
    localparam int LINE_BYTES_MAX = 50;
    localparam int LINES_MIN      = 1;
    localparam int LINES_MAX      = 4095;
    localparam int DIGITS_MIN     = 1;
    localparam int DIGITS_MAX     = 15;

    localparam int I_IDLE  = 0;
    localparam int I_HDR   = 1;
    localparam int I_PACK  = 2;
    localparam int I_STRB  = 3;
    localparam int I_GUARD = 4;
    localparam int I_WAITB = 5;
    localparam int I_RESP  = 6;
    localparam int I_DONE  = 7;

    typedef enum logic [7:0] {
        S_IDLE  = 8'b0000_0001,
        S_HDR   = 8'b0000_0010,
        S_PACK  = 8'b0000_0100,
        S_STRB  = 8'b0000_1000,
        S_GUARD = 8'b0001_0000,
        S_WAITB = 8'b0010_0000,
        S_RESP  = 8'b0100_0000,
        S_DONE  = 8'b1000_0000
    } state_t;

    function automatic logic cfg_ok(
        logic [7:0]  lb,
        logic [11:0] ln,
        logic [3:0]  dg
    );
        return int'(lb) >= LINE_BYTES_MIN && int'(lb) <= LINE_BYTES_MAX
            && int'(ln) >= LINES_MIN && int'(ln) <= LINES_MAX
            && int'(dg) >= DIGITS_MIN && int'(dg) <= DIGITS_MAX;
    endfunction

    function automatic logic [7:0] hdr_byte(
        logic [7:0]  magic,
        logic [1:0]  idx,
        logic [7:0]  lb,
        logic [11:0] ln,
        logic [3:0]  dg
    );
        logic [7:0] b;
        case (idx)
            2'd0:    b = magic;
            2'd1:    b = lb;
            2'd2:    b = ln[11:4];
            default: b = {ln[3:0], dg};
        endcase
        return b;
    endfunction

    // Byte idx lands big-endian: idx 0 occupies bits 63:56.
    function automatic logic [63:0] put_byte(
        logic [63:0] r,
        logic [2:0]  idx,
        logic [7:0]  b
    );
        logic [63:0] o;
        o = r;
        o[{3'd7 - idx, 3'b000} +: 8] = b;
        return o;
    endfunction

endpackage

// File: rtl/resp_collect.sv
// Gathers the 8-byte accelerator response and flags a silent receiver.
// Always clears the UART receiver after a byte, even when not collecting.
module resp_collect
    import aoc_uart_pkg::*;
#(
    parameter logic [23:0] RESP_TIMEOUT = 24'd12_000_000
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  rx_value,
    input  logic        rx_recd,
    output logic [63:0] result,
    output logic        rx_reset,
    output logic        full,
    output logic        timeout
);

    logic [2:0]  cnt;
    logic [23:0] tmo;
    logic        enable_q;
    logic        take;
    logic [63:0] base;

    // A byte seen while the receiver is still being cleared is a repeat.
    assign take = rx_recd && !rx_reset;
    assign base = enable_q ? result : 64'd0;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            result   <= 64'd0;
            rx_reset <= 1'b0;
            full     <= 1'b0;
            timeout  <= 1'b0;
            cnt      <= 3'd0;
            tmo      <= 24'd0;
            enable_q <= 1'b0;
        end else begin
            enable_q <= enable;
            rx_reset <= take;
            timeout  <= 1'b0;
            if (!enable) begin
                cnt  <= 3'd0;
                tmo  <= 24'd0;
                full <= 1'b0;
            end else if (!full && !timeout) begin
                if (take) begin
                    result <= put_byte(base, cnt, rx_value);
                    cnt    <= cnt + 3'd1;
                    full   <= (cnt == 3'(RESULT_BYTES - 1));
                    tmo    <= 24'd0;
                end else begin
                    if (!enable_q) begin
                        result <= 64'd0;
                    end
                    if (tmo == RESP_TIMEOUT - 24'd1) begin
                        timeout <= 1'b1;
                        tmo     <= 24'd0;
                    end else begin
                        tmo <= tmo + 24'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/job_tx.sv
// Streams a header plus packed BCD lines to the UART accelerator,
// then collects its 64-bit big-endian sum.
module job_tx
    import aoc_uart_pkg::*;
#(
    parameter logic [23:0] RESP_TIMEOUT = 24'd12_000_000,
    parameter logic [7:0]  HDR_MAGIC    = aoc_uart_pkg::HDR_MAGIC
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  cfg_line_bytes,
    input  logic [11:0] cfg_lines,
    input  logic [3:0]  cfg_digits,
    input  logic        dig_valid,
    output logic        dig_ready,
    input  logic [3:0]  dig_data,
    output logic [7:0]  tx_data,
    output logic        tx_xmit,
    input  logic        tx_ready,
    input  logic [7:0]  rx_value,
    input  logic        rx_recd,
    output logic        rx_reset,
    output logic        busy,
    output logic [63:0] result,
    output logic        done,
    output logic        err
);

    state_t      state;
    logic [7:0]  lb_q;
    logic [11:0] ln_q;
    logic [3:0]  dg_q;
    logic [1:0]  hdr_idx;
    logic        in_hdr;
    logic        nib_lo;
    logic [7:0]  byte_cnt;
    logic [11:0] line_cnt;
    logic        full;
    logic        timeout;

    assign busy      = !state[I_IDLE];
    assign dig_ready = state[I_PACK];

    resp_collect #(
        .RESP_TIMEOUT(RESP_TIMEOUT)
    ) u_resp (
        .sysclk  (sysclk),
        .reset   (reset),
        .enable  (state[I_RESP]),
        .rx_value(rx_value),
        .rx_recd (rx_recd),
        .result  (result),
        .rx_reset(rx_reset),
        .full    (full),
        .timeout (timeout)
    );

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state    <= S_IDLE;
            lb_q     <= 8'd0;
            ln_q     <= 12'd0;
            dg_q     <= 4'd0;
            hdr_idx  <= 2'd0;
            in_hdr   <= 1'b0;
            nib_lo   <= 1'b0;
            byte_cnt <= 8'd0;
            line_cnt <= 12'd0;
            tx_data  <= 8'd0;
            tx_xmit  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (1'b1)
                state[I_IDLE]: begin
                    if (start) begin
                        if (cfg_ok(cfg_line_bytes, cfg_lines, cfg_digits)) begin
                            lb_q     <= cfg_line_bytes;
                            ln_q     <= cfg_lines;
                            dg_q     <= cfg_digits;
                            err      <= 1'b0;
                            byte_cnt <= 8'd0;
                            line_cnt <= 12'd0;
                            hdr_idx  <= 2'd0;
                            in_hdr   <= 1'b1;
                            nib_lo   <= 1'b0;
                            state    <= S_HDR;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                state[I_HDR]: begin
                    tx_data <= hdr_byte(HDR_MAGIC, hdr_idx, lb_q, ln_q, dg_q);
                    state   <= S_STRB;
                end
                state[I_PACK]: begin
                    if (dig_valid) begin
                        if (dig_data > 4'd9) begin
                            err <= 1'b1;
                        end
                        if (!nib_lo) begin
                            tx_data[7:4] <= dig_data;
                            nib_lo       <= 1'b1;
                        end else begin
                            tx_data[3:0] <= dig_data;
                            nib_lo       <= 1'b0;
                            state        <= S_STRB;
                        end
                    end
                end
                // Header and data bytes share this strobe/guard/wait path.
                state[I_STRB]: begin
                    if (tx_xmit) begin
                        tx_xmit <= 1'b0;
                        state   <= S_GUARD;
                    end else if (tx_ready) begin
                        tx_xmit <= 1'b1;
                    end
                end
                state[I_GUARD]: begin
                    state <= S_WAITB;
                end
                state[I_WAITB]: begin
                    if (tx_ready) begin
                        if (in_hdr) begin
                            if (hdr_idx == 2'(HDR_BYTES - 1)) begin
                                in_hdr <= 1'b0;
                                state  <= S_PACK;
                            end else begin
                                hdr_idx <= hdr_idx + 2'd1;
                                state   <= S_HDR;
                            end
                        end else if (byte_cnt == lb_q - 8'd1) begin
                            byte_cnt <= 8'd0;
                            if (line_cnt == ln_q - 12'd1) begin
                                state <= S_RESP;
                            end else begin
                                line_cnt <= line_cnt + 12'd1;
                                state    <= S_PACK;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                            state    <= S_PACK;
                        end
                    end
                end
                state[I_RESP]: begin
                    if (full) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (timeout) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                state[I_DONE]: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_job_tx.sv
// Directed and randomized jobs for job_tx against a byte-level model
// of the expected UART traffic and response.
module tb_job_tx;

    localparam logic [23:0] TMO = 24'd1000;

    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cfg_line_bytes = 8'd1;
    logic [11:0] cfg_lines = 12'd1;
    logic [3:0]  cfg_digits = 4'd1;
    logic        dig_valid = 1'b0;
    logic        dig_ready;
    logic [3:0]  dig_data = 4'd0;
    logic [7:0]  tx_data;
    logic        tx_xmit;
    logic        tx_ready = 1'b1;
    logic [7:0]  rx_value = 8'd0;
    logic        rx_recd = 1'b0;
    logic        rx_reset;
    logic        busy;
    logic [63:0] result;
    logic        done;
    logic        err;

    job_tx #(
        .RESP_TIMEOUT(TMO),
        .HDR_MAGIC   (8'hAA)
    ) dut (
        .sysclk        (sysclk),
        .reset         (reset),
        .start         (start),
        .cfg_line_bytes(cfg_line_bytes),
        .cfg_lines     (cfg_lines),
        .cfg_digits    (cfg_digits),
        .dig_valid     (dig_valid),
        .dig_ready     (dig_ready),
        .dig_data      (dig_data),
        .tx_data       (tx_data),
        .tx_xmit       (tx_xmit),
        .tx_ready      (tx_ready),
        .rx_value      (rx_value),
        .rx_recd       (rx_recd),
        .rx_reset      (rx_reset),
        .busy          (busy),
        .result        (result),
        .done          (done),
        .err           (err)
    );

    always #5 sysclk = ~sysclk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0] tx_log[$];
    logic [3:0] dig_q[$];
    logic [7:0] rx_q[$];

    int tx_busy = 0;
    int rx_wait = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_rx_cyc = 0;
    int viol = 0;
    bit stall = 0;
    bit rx_en = 0;
    bit rx_hold = 0;
    bit dv_q = 0;
    bit dr_q = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: observe the edge just taken, then drive the next cycle.
    task automatic tick();
        @(posedge sysclk);
        #1;
        cyc++;
        if (dv_q && dr_q && dig_q.size() > 0) dig_q.delete(0);
        if (tx_xmit) begin
            tx_log.push_back(tx_data);
            tx_ready = 1'b0;
            tx_busy  = $urandom_range(1, 4);
        end else if (tx_busy > 0) begin
            tx_busy--;
        end else begin
            tx_ready = !stall;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (dig_ready && !stall && (tx_xmit || !tx_ready)) viol++;
        if (dig_q.size() > 0) begin
            dig_valid = ($urandom_range(0, 3) != 0);
            dig_data  = dig_q[0];
        end else begin
            dig_valid = 1'b0;
        end
        dv_q = dig_valid;
        dr_q = dig_ready;
        if (rx_recd) begin
            if (rx_hold) rx_hold = 0;
            else rx_recd = 1'b0;
        end else if (rx_en && rx_q.size() > 0) begin
            if (rx_wait > 0) begin
                rx_wait--;
            end else begin
                rx_recd     = 1'b1;
                rx_value    = rx_q.pop_front();
                rx_hold     = bit'($urandom_range(0, 1));
                rx_wait     = $urandom_range(1, 5);
                last_rx_cyc = cyc;
            end
        end
    endtask

    task automatic fill_job(input int lb, input int ln, input int nresp);
        for (int i = 0; i < 2 * lb * ln; i++)
            dig_q.push_back(4'($urandom_range(0, 9)));
        for (int k = 0; k < nresp; k++)
            rx_q.push_back(8'($urandom));
    endtask

    task automatic run_job(input logic [7:0] lb, input logic [11:0] ln,
                           input logic [3:0] dg, input int stall_cyc);
        logic [7:0]  exp_tx[$];
        logic [63:0] exp_res;
        bit          exp_err;
        int          n_resp;
        int          n_tx;
        int          limit;
        int          dt;
        exp_tx.push_back(8'hAA);
        exp_tx.push_back(lb);
        exp_tx.push_back(ln[11:4]);
        exp_tx.push_back({ln[3:0], dg});
        for (int i = 0; i + 1 < dig_q.size(); i += 2)
            exp_tx.push_back({dig_q[i], dig_q[i+1]});
        exp_err = 0;
        foreach (dig_q[i]) if (dig_q[i] > 4'd9) exp_err = 1;
        n_resp  = rx_q.size();
        exp_res = 64'd0;
        for (int k = 0; k < n_resp; k++) exp_res[63 - 8 * k -: 8] = rx_q[k];
        if (n_resp < 8) exp_err = 1;
        n_tx = exp_tx.size();

        tx_log.delete();
        done_cnt = 0;
        rx_en = 0;
        cfg_line_bytes = lb;
        cfg_lines = ln;
        cfg_digits = dg;
        start = 1'b1;
        if (stall_cyc > 0) begin
            stall = 1;
            tx_ready = 1'b0;
        end
        tick();
        start = 1'b0;
        if (stall_cyc > 0) begin
            repeat (stall_cyc) tick();
            chk("stall_no_xmit", tx_log.size(), 0);
            chk("stall_busy", busy, 1);
            stall = 0;
        end
        limit = 0;
        while (done_cnt == 0 && limit < 20000) begin
            if (limit == 7) begin
                cfg_lines = 12'd3;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            if (!rx_en && tx_log.size() >= n_tx) begin
                rx_en = 1;
                rx_wait = 20;
            end
            limit++;
        end
        chk("done_seen", done_cnt > 0, 1);
        repeat (5) tick();
        chk("tx_count", tx_log.size(), n_tx);
        for (int i = 0; i < n_tx && i < tx_log.size(); i++)
            chk($sformatf("tx_byte%0d", i), tx_log[i], exp_tx[i]);
        chk("done_pulses", done_cnt, 1);
        chk("err", err, exp_err);
        chk("busy_after", busy, 0);
        chk("digits_consumed", dig_q.size(), 0);
        if (n_resp == 8) begin
            chk("result", result, exp_res);
        end else begin
            dt = done_cyc - last_rx_cyc;
            chk("result_partial", result[63:40], exp_res[63:40]);
            chk("timeout_delay", dt >= int'(TMO) && dt <= int'(TMO) + 8, 1);
        end
        rx_en = 0;
        rx_q.delete();
    endtask

    initial begin
        logic [63:0] r0;
        int          lim;
        logic [7:0]  bad_lb[4];
        logic [11:0] bad_ln[4];
        logic [3:0]  bad_dg[4];

        reset = 1'b1;
        repeat (3) begin
            tick();
            chk("reset_ctrl",
                {tx_xmit, rx_reset, dig_ready, busy, done, err, tx_data}, 0);
            chk("reset_result", result, 0);
        end
        reset = 1'b0;
        tick();

        dig_q = '{4'd9, 4'd8};
        rx_q  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h62};
        run_job(8'd1, 12'd1, 4'd2, 0);

        dig_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        fill_job(0, 0, 8);
        run_job(8'd2, 12'd2, 4'd5, 0);
        chk("dig_ready_only_in_pack", viol, 0);

        fill_job(1, 2, 8);
        run_job(8'd1, 12'd2, 4'd3, 500);

        fill_job(2, 1, 3);
        run_job(8'd2, 12'd1, 4'd4, 0);

        r0 = result;
        rx_value = 8'h5A;
        rx_recd = 1'b1;
        tick();
        chk("stray_rx_reset", rx_reset, 1);
        tick();
        chk("stray_rx_result", result, r0);
        chk("stray_rx_busy", busy, 0);

        fill_job(4, 2, 0);
        cfg_line_bytes = 8'd4;
        cfg_lines = 12'd2;
        cfg_digits = 4'd6;
        tx_log.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        lim = 0;
        while (tx_log.size() < 6 && lim < 2000) begin
            tick();
            lim++;
        end
        chk("reached_byte6", tx_log.size(), 6);
        reset = 1'b1;
        repeat (3) begin
            tick();
            chk("midjob_reset_ctrl",
                {tx_xmit, rx_reset, dig_ready, busy, done, err, tx_data}, 0);
            chk("midjob_reset_result", result, 0);
        end
        reset = 1'b0;
        dig_q.delete();
        rx_q.delete();
        dig_valid = 1'b0;
        dv_q = 0;
        dr_q = 0;
        tx_ready = 1'b1;
        tx_busy = 0;
        tick();
        fill_job(3, 2, 8);
        run_job(8'd3, 12'd2, 4'd9, 0);

        bad_lb = '{8'd3, 8'd51, 8'd1, 8'd0};
        bad_ln = '{12'd0, 12'd1, 12'd1, 12'd1};
        bad_dg = '{4'd2, 4'd2, 4'd0, 4'd2};
        for (int j = 0; j < 4; j++) begin
            tx_log.delete();
            cfg_line_bytes = bad_lb[j];
            cfg_lines = bad_ln[j];
            cfg_digits = bad_dg[j];
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (10) tick();
            chk($sformatf("badcfg%0d_err", j), err, 1);
            chk($sformatf("badcfg%0d_busy", j), busy, 0);
            chk($sformatf("badcfg%0d_noxmit", j), tx_log.size(), 0);
        end

        fill_job(2, 2, 8);
        run_job(8'd2, 12'd2, 4'd1, 0);

        fill_job(3, 1, 8);
        dig_q[3] = 4'hC;
        run_job(8'd3, 12'd1, 4'd7, 0);

        for (int j = 0; j < 4; j++) begin
            int lb;
            int ln;
            lb = $urandom_range(1, 6);
            ln = $urandom_range(1, 4);
            fill_job(lb, ln, 8);
            run_job(8'(lb), 12'(ln), 4'($urandom_range(1, 15)), 0);
        end

        fill_job(50, 1, 8);
        run_job(8'd50, 12'd1, 4'd15, 0);

        chk("dig_ready_final", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
